// File: rtl/util_tx_timestamp_gate_if.sv
// Stream bundle around the timestamp gate: unpacker-side input and DAC-side output.
// The master modport is the gate's view; slave is the surrounding logic.
interface util_tx_timestamp_gate_if #(
  parameter int DW = 64
);
  logic          s_axis_xfer_req;
  logic          s_axis_valid;
  logic          s_axis_ready;
  logic [DW-1:0] s_axis_data;
  logic          m_axis_valid;
  logic          m_axis_ready;
  logic          m_axis_last;
  logic [DW-1:0] m_axis_data;

  modport master (
    input  s_axis_xfer_req, s_axis_valid, s_axis_data, m_axis_ready,
    output s_axis_ready, m_axis_valid, m_axis_last, m_axis_data
  );

  modport slave (
    output s_axis_xfer_req, s_axis_valid, s_axis_data, m_axis_ready,
    input  s_axis_ready, m_axis_valid, m_axis_last, m_axis_data
  );
endinterface

// File: rtl/util_tx_timestamp_gate.sv
// TX timestamp gate: strips block headers, buffers payload in a FWFT FIFO and
// releases each block once the DAC timestamp reaches the block's timestamp.
module util_tx_timestamp_gate #(
  parameter int NUM_OF_CHANNELS                = 4,
  parameter int SAMPLES_PER_CHANNEL            = 1,
  parameter int SAMPLE_DATA_WIDTH              = 16,
  parameter int TIMESTAMP_WIDTH                = 64,
  parameter int FIFO_DEPTH_LOG2                = 4,
  parameter int TIMESTAMP_LIMIT_EVERY_MULTIPLE = 16
) (
  input  logic                         dac_clk,
  input  logic                         reset,
  input  logic [TIMESTAMP_WIDTH-1:0]   timestamp,
  input  logic [31:0]                  timestamp_every,
  input  logic [1:0]                   late_mode,
  util_tx_timestamp_gate_if.master     axis,
  output logic                         reset_upack,
  output logic [FIFO_DEPTH_LOG2:0]     fifo_level,
  output logic [31:0]                  discarded_block_count,
  output logic [31:0]                  late_block_count,
  output logic [31:0]                  underflow_count
);

  localparam int DW    = NUM_OF_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_DATA_WIDTH;
  localparam int TW    = TIMESTAMP_WIDTH;
  localparam int AW    = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int LW    = TW + 64;

  typedef struct packed {
    logic          ts_valid;
    logic          last;
    logic [TW-1:0] ts;
    logic [DW-1:0] data;
  } entry_t;

  logic          xfer_req_q, xfer_req_d;
  logic          rise_q, rise_d;
  logic [31:0]   every_q, every_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          discard_q, discard_d;
  logic [TW-1:0] hdr_ts_q, hdr_ts_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          head_seen_q, head_seen_d;
  logic          in_block_q, in_block_d;
  logic [31:0]   disc_cnt_q, disc_cnt_d;
  logic [31:0]   late_cnt_q, late_cnt_d;
  logic [31:0]   udf_cnt_q, udf_cnt_d;

  entry_t        mem_q [DEPTH];

  logic          rise, start_pulse;
  logic [AW:0]   level;
  logic          empty, full;
  entry_t        head, wr_entry;
  logic          is_header;
  logic [TW-1:0] hdr_ts, limit;
  logic [LW-1:0] limit_wide;
  logic          too_early, too_late, drop_block;
  logic          s_ready, accept, wr_en;
  logic          m_valid, pop;

  always_comb begin
    rise        = axis.s_axis_xfer_req & ~xfer_req_q;
    start_pulse = rise | rise_q;
    level       = wr_ptr_q - rd_ptr_q;
    empty       = (level == '0);
    full        = (level == (AW+1)'(DEPTH));
    head        = mem_q[rd_ptr_q[AW-1:0]];
    is_header   = (every_q != 32'd0) && (cnt_q == 32'd0);
    hdr_ts      = axis.s_axis_data[TW-1:0];

    // Window end saturates so a timestamp near wrap never makes every header look early.
    limit_wide  = LW'(timestamp) + LW'(every_q) * LW'(TIMESTAMP_LIMIT_EVERY_MULTIPLE);
    limit       = (|limit_wide[LW-1:TW]) ? '1 : limit_wide[TW-1:0];
    too_early   = hdr_ts > limit;
    too_late    = (hdr_ts < timestamp) && (late_mode != 2'd1);
    drop_block  = too_early | too_late;

    s_ready     = axis.s_axis_xfer_req & ~start_pulse & (~full | is_header | discard_q);
    accept      = axis.s_axis_valid & s_ready;
    wr_en       = accept & ~is_header & ~discard_q;

    wr_entry.ts_valid = (every_q != 32'd0) && (cnt_q == 32'd1);
    wr_entry.last     = (every_q != 32'd0) && (cnt_q == every_q);
    wr_entry.ts       = hdr_ts_q;
    wr_entry.data     = axis.s_axis_data;

    m_valid     = ~empty & ~start_pulse & (~head.ts_valid | (timestamp >= head.ts));
    pop         = m_valid & axis.m_axis_ready;
  end

  always_comb begin
    xfer_req_d  = axis.s_axis_xfer_req;
    rise_d      = rise;
    every_d     = every_q;
    cnt_d       = cnt_q;
    discard_d   = discard_q;
    hdr_ts_d    = hdr_ts_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_seen_d = head_seen_q;
    in_block_d  = in_block_q;
    disc_cnt_d  = disc_cnt_q;
    late_cnt_d  = late_cnt_q;
    udf_cnt_d   = udf_cnt_q;

    // Block length only changes at a transfer boundary.
    if (rise) every_d = timestamp_every;

    if (start_pulse || !axis.s_axis_xfer_req) begin
      cnt_d     = '0;
      discard_d = 1'b0;
    end else if (accept) begin
      if (every_q == 32'd0 || cnt_q == every_q) cnt_d = '0;
      else                                      cnt_d = cnt_q + 32'd1;
      if (is_header) begin
        discard_d = drop_block;
        hdr_ts_d  = hdr_ts;
        if (drop_block) disc_cnt_d = disc_cnt_q + 32'd1;
      end
    end

    if (start_pulse) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      head_seen_d = 1'b0;
      in_block_d  = 1'b0;
    end else begin
      if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
      // Lateness is judged once, on the first cycle a block's first beat sits at the head.
      if (!empty && head.ts_valid && !head_seen_q) begin
        head_seen_d = 1'b1;
        if (head.ts < timestamp) late_cnt_d = late_cnt_q + 32'd1;
      end
      if (pop) head_seen_d = 1'b0;
      if (pop && head.last)          in_block_d = 1'b0;
      else if (pop && head.ts_valid) in_block_d = 1'b1;
    end

    if (in_block_q && empty && axis.m_axis_ready) udf_cnt_d = udf_cnt_q + 32'd1;
  end

  always_ff @(posedge dac_clk or posedge reset) begin
    if (reset) begin
      xfer_req_q  <= 1'b0;
      rise_q      <= 1'b0;
      every_q     <= '0;
      cnt_q       <= '0;
      discard_q   <= 1'b0;
      hdr_ts_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      head_seen_q <= 1'b0;
      in_block_q  <= 1'b0;
      disc_cnt_q  <= '0;
      late_cnt_q  <= '0;
      udf_cnt_q   <= '0;
    end else begin
      xfer_req_q  <= xfer_req_d;
      rise_q      <= rise_d;
      every_q     <= every_d;
      cnt_q       <= cnt_d;
      discard_q   <= discard_d;
      hdr_ts_q    <= hdr_ts_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      head_seen_q <= head_seen_d;
      in_block_q  <= in_block_d;
      disc_cnt_q  <= disc_cnt_d;
      late_cnt_q  <= late_cnt_d;
      udf_cnt_q   <= udf_cnt_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by the pointers.
  always_ff @(posedge dac_clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wr_entry;
  end

  assign axis.s_axis_ready  = s_ready;
  assign axis.m_axis_valid  = m_valid;
  assign axis.m_axis_data   = head.data;
  assign axis.m_axis_last   = head.last & m_valid;
  assign reset_upack        = reset | start_pulse;
  assign fifo_level         = level;
  assign discarded_block_count = disc_cnt_q;
  assign late_block_count   = late_cnt_q;
  assign underflow_count    = udf_cnt_q;

endmodule

// File: tb/tb_util_tx_timestamp_gate.sv
// Bench for util_tx_timestamp_gate: directed scenarios plus randomized blocks
// checked against a block-level queue model of the gate.
module tb_util_tx_timestamp_gate;

  localparam logic [63:0] MAXTS = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int          MULT  = 16;

  logic        dac_clk = 1'b0;
  logic        reset;
  logic [63:0] timestamp;
  logic [31:0] timestamp_every;
  logic [1:0]  late_mode;
  logic        reset_upack;
  logic [4:0]  fifo_level;
  logic [31:0] discarded_block_count, late_block_count, underflow_count;

  util_tx_timestamp_gate_if #(.DW(64)) bus();

  util_tx_timestamp_gate dut (
    .dac_clk               (dac_clk),
    .reset                 (reset),
    .timestamp             (timestamp),
    .timestamp_every       (timestamp_every),
    .late_mode             (late_mode),
    .axis                  (bus),
    .reset_upack           (reset_upack),
    .fifo_level            (fifo_level),
    .discarded_block_count (discarded_block_count),
    .late_block_count      (late_block_count),
    .underflow_count       (underflow_count)
  );

  always #5 dac_clk = ~dac_clk;

  typedef struct {
    logic [63:0] data;
    logic        last;
    logic [63:0] gate;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          exp_disc, exp_late;
  logic [31:0] cur_every;
  logic        rand_ready, ts_run;

  // Output monitor: every popped beat must match the model queue and respect its release time.
  always @(negedge dac_clk) begin
    if (!reset && bus.m_axis_valid && bus.m_axis_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_beat: got data=%h last=%b, required no output", bus.m_axis_data, bus.m_axis_last);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.m_axis_data !== mon_e.data || bus.m_axis_last !== mon_e.last || timestamp < mon_e.gate) begin
          bad++;
          $display("FAIL out_beat: got data=%h last=%b at ts=%0d, required data=%h last=%b at ts>=%0d",
                   bus.m_axis_data, bus.m_axis_last, timestamp, mon_e.data, mon_e.last, mon_e.gate);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge dac_clk);
    #1;
    if (ts_run) timestamp = timestamp + 64'd1;
    if (rand_ready) bus.m_axis_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.s_axis_xfer_req = 1'b0;
    bus.s_axis_valid = 1'b0;
    bus.s_axis_data = '0;
    bus.m_axis_ready = 1'b0;
    rand_ready = 1'b0;
    ts_run = 1'b0;
    timestamp = '0;
    timestamp_every = '0;
    late_mode = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    exp_q.delete();
    exp_disc = 0;
    exp_late = 0;
  endtask

  task automatic start_xfer(input logic [31:0] ev);
    bus.s_axis_xfer_req = 1'b0;
    tick();
    timestamp_every = ev;
    cur_every = ev;
    bus.s_axis_xfer_req = 1'b1;
    tick();
    tick();
  endtask

  task automatic send_beat(input logic [63:0] d, output logic [63:0] ts_at);
    int n;
    n = 0;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data = d;
    while (!bus.s_axis_ready && n < 300) begin
      tick();
      n++;
    end
    total++;
    if (!bus.s_axis_ready) begin
      bad++;
      $display("FAIL send_timeout: got s_axis_ready=0 for %0d cycles, required 1", n);
    end
    ts_at = timestamp;
    tick();
    bus.s_axis_valid = 1'b0;
  endtask

  // Model: classify the header against the timestamp seen when it was accepted.
  task automatic send_block(input logic [63:0] hts, input int n, input int gap_max,
                            input int pause_after, input int pause_len);
    logic [63:0] t, span, lim, d;
    logic        acc;
    exp_t        e;
    send_beat(hts, t);
    span = 64'(cur_every) * 64'(MULT);
    lim  = (t > MAXTS - span) ? MAXTS : t + span;
    acc  = !(hts > lim) && !(hts < t && late_mode != 2'd1);
    if (!acc) exp_disc++;
    else if (hts < t) exp_late++;
    for (int i = 1; i <= n; i++) begin
      repeat ($urandom_range(0, gap_max)) tick();
      d = {$urandom, $urandom};
      send_beat(d, t);
      if (acc) begin
        e.data = d;
        e.last = (i == n);
        e.gate = (i == 1) ? hts : 64'd0;
        exp_q.push_back(e);
      end
      if (i == pause_after) repeat (pause_len) tick();
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d beats outstanding, required 0", exp_q.size());
    end
    repeat (2) tick();
  endtask

  task automatic check_counters(input string name);
    total++;
    if (discarded_block_count !== 32'(exp_disc) || late_block_count !== 32'(exp_late)) begin
      bad++;
      $display("FAIL %s_counters: got discarded=%0d late=%0d, required discarded=%0d late=%0d",
               name, discarded_block_count, late_block_count, exp_disc, exp_late);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.s_axis_xfer_req = 1'b0;
    bus.s_axis_valid = 1'b0;
    bus.m_axis_ready = 1'b1;
    timestamp = '0;
    timestamp_every = '0;
    late_mode = 2'd0;
    rand_ready = 1'b0;
    ts_run = 1'b0;
    repeat (2) tick();
    total++;
    if (bus.s_axis_ready !== 1'b0 || bus.m_axis_valid !== 1'b0 || bus.m_axis_last !== 1'b0 ||
        reset_upack !== 1'b1 || fifo_level !== 5'd0) begin
      bad++;
      $display("FAIL reset_outputs: got ready=%b valid=%b last=%b upack=%b level=%0d, required 0 0 0 1 0",
               bus.s_axis_ready, bus.m_axis_valid, bus.m_axis_last, reset_upack, fifo_level);
    end
    total++;
    if (discarded_block_count !== 0 || late_block_count !== 0 || underflow_count !== 0) begin
      bad++;
      $display("FAIL reset_counters: got %0d %0d %0d, required 0 0 0",
               discarded_block_count, late_block_count, underflow_count);
    end
    do_reset();
    total++;
    if (reset_upack !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: got reset_upack=%b, required 0", reset_upack);
    end
  endtask

  task automatic test_gate_hold();
    int early;
    do_reset();
    timestamp = 64'd100;
    bus.m_axis_ready = 1'b1;
    start_xfer(32'd4);
    send_block(64'd120, 4, 0, 0, 0);
    early = 0;
    for (int t = 101; t < 120; t++) begin
      timestamp = 64'(t);
      #1;
      if (bus.m_axis_valid) early++;
      tick();
    end
    total++;
    if (early != 0 || fifo_level !== 5'd4) begin
      bad++;
      $display("FAIL gate_hold: got %0d early valid cycles level=%0d, required 0 and 4", early, fifo_level);
    end
    timestamp = 64'd120;
    #1;
    total++;
    if (bus.m_axis_valid !== 1'b1) begin
      bad++;
      $display("FAIL gate_release: got m_axis_valid=%b at ts=120, required 1", bus.m_axis_valid);
    end
    wait_drain();
    check_counters("gate");
    total++;
    if (underflow_count !== 0) begin
      bad++;
      $display("FAIL gate_underflow: got %0d, required 0", underflow_count);
    end
  endtask

  task automatic test_late(input logic [1:0] mode);
    do_reset();
    timestamp = 64'd100;
    late_mode = mode;
    bus.m_axis_ready = 1'b1;
    start_xfer(32'd4);
    send_block(64'd90, 4, 0, 0, 0);
    wait_drain();
    check_counters(mode == 2'd1 ? "late_send" : "late_drop");
    total++;
    if (fifo_level !== 5'd0 || bus.m_axis_valid !== 1'b0) begin
      bad++;
      $display("FAIL late_idle: got level=%0d valid=%b, required 0 0", fifo_level, bus.m_axis_valid);
    end
  endtask

  task automatic test_early_window();
    do_reset();
    timestamp = 64'd100;
    bus.m_axis_ready = 1'b1;
    start_xfer(32'd4);
    send_block(64'd165, 4, 0, 0, 0);
    send_block(64'd164, 4, 0, 0, 0);
    tick();
    total++;
    if (fifo_level !== 5'd4) begin
      bad++;
      $display("FAIL early_level: got %0d, required 4", fifo_level);
    end
    ts_run = 1'b1;
    wait_drain();
    ts_run = 1'b0;
    check_counters("early");
    timestamp = 64'hFFFF_FFFF_FFFF_FFF0;
    send_block(MAXTS, 4, 0, 0, 0);
    ts_run = 1'b1;
    wait_drain();
    ts_run = 1'b0;
    check_counters("early_saturate");
  endtask

  task automatic test_underflow();
    do_reset();
    timestamp = 64'd100;
    bus.m_axis_ready = 1'b1;
    start_xfer(32'd8);
    send_block(64'd100, 8, 0, 2, 3);
    wait_drain();
    total++;
    if (underflow_count !== 32'd3) begin
      bad++;
      $display("FAIL underflow: got %0d, required 3", underflow_count);
    end
    check_counters("underflow");
  endtask

  task automatic test_passthrough_flush();
    logic [63:0] t, d;
    exp_t        e;
    do_reset();
    bus.m_axis_ready = 1'b0;
    start_xfer(32'd0);
    for (int i = 0; i < 16; i++) begin
      d = {$urandom, $urandom};
      send_beat(d, t);
      e.data = d; e.last = 1'b0; e.gate = 64'd0;
      exp_q.push_back(e);
    end
    total++;
    if (fifo_level !== 5'd16 || bus.s_axis_ready !== 1'b0) begin
      bad++;
      $display("FAIL pass_full: got level=%0d ready=%b, required 16 0", fifo_level, bus.s_axis_ready);
    end
    bus.s_axis_xfer_req = 1'b0;
    tick();
    bus.s_axis_xfer_req = 1'b1;
    #1;
    total++;
    if (reset_upack !== 1'b1 || bus.s_axis_ready !== 1'b0) begin
      bad++;
      $display("FAIL start_pulse1: got upack=%b ready=%b, required 1 0", reset_upack, bus.s_axis_ready);
    end
    tick();
    exp_q.delete();
    total++;
    if (reset_upack !== 1'b1 || fifo_level !== 5'd0 || bus.m_axis_valid !== 1'b0) begin
      bad++;
      $display("FAIL start_pulse2: got upack=%b level=%0d valid=%b, required 1 0 0",
               reset_upack, fifo_level, bus.m_axis_valid);
    end
    tick();
    total++;
    if (reset_upack !== 1'b0 || bus.s_axis_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_end: got upack=%b ready=%b, required 0 1", reset_upack, bus.s_axis_ready);
    end
    bus.m_axis_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = {$urandom, $urandom};
      send_beat(d, t);
      e.data = d; e.last = 1'b0; e.gate = 64'd0;
      exp_q.push_back(e);
    end
    wait_drain();
    check_counters("pass");
  endtask

  task automatic test_random_blocks();
    logic [63:0] hts, span;
    int          cat;
    logic [31:0] ev;
    do_reset();
    rand_ready = 1'b1;
    timestamp = 64'd1000;
    for (int tr = 0; tr < 4; tr++) begin
      ev = 32'($urandom_range(1, 6));
      late_mode = 2'($urandom_range(0, 3));
      start_xfer(ev);
      span = 64'(ev) * 64'(MULT);
      for (int b = 0; b < 6; b++) begin
        cat = $urandom_range(0, 3);
        case (cat)
          0:       hts = timestamp;
          1:       hts = timestamp + 64'($urandom_range(1, 32'(span)));
          2:       hts = timestamp - 64'($urandom_range(1, 50));
          default: hts = timestamp + span + 64'($urandom_range(1, 100));
        endcase
        send_block(hts, int'(ev), 2, 0, 0);
        ts_run = 1'b1;
        wait_drain();
        ts_run = 1'b0;
      end
      check_counters("random");
      total++;
      if (fifo_level !== 5'd0) begin
        bad++;
        $display("FAIL random_level: got %0d, required 0", fifo_level);
      end
    end
    rand_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_gate_hold();
    test_late(2'd0);
    test_late(2'd1);
    test_late(2'd2);
    test_early_window();
    test_underflow();
    test_passthrough_flush();
    test_random_blocks();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/util_tx_timestamp_gate.md
Name: util_tx_timestamp_gate

Overview:
Single-clock timestamp gate for the TX path, sitting between the DMA-side unpacker and the DAC data path; the stream is already in the DAC clock domain.
- Parses a timestamp header beat at the start of every timestamped block and buffers payload beats in a parametrised synchronous FIFO.
- Holds each block until the free-running DAC timestamp reaches the block's timestamp.
- Adds a selectable late-block policy, an in-block underflow counter, a late counter, end-of-block marking and a FIFO level output.

Parameters:
NUM_OF_CHANNELS, 4, channels per beat
SAMPLES_PER_CHANNEL, 1, samples per channel per beat
SAMPLE_DATA_WIDTH, 16, bits per sample; DW = product of the three parameters
TIMESTAMP_WIDTH, 64, timestamp bits; must be <= DW; the header timestamp is data[TIMESTAMP_WIDTH-1:0]
FIFO_DEPTH_LOG2, 4, FIFO depth = 2**FIFO_DEPTH_LOG2 entries
TIMESTAMP_LIMIT_EVERY_MULTIPLE, 16, too-early window = timestamp_every * this value

Ports:
dac_clk  in  1  sole clock
reset  in  1  asynchronous, active-high
timestamp  in  TIMESTAMP_WIDTH  current DAC sample time
timestamp_every  in  32  payload beats per block; 0 = passthrough, no headers
late_mode  in  2  0 = discard late block, 1 = send late block immediately, 2/3 = treated as 0
s_axis_xfer_req  in  1  transfer in progress
s_axis_valid  in  1  input beat valid
s_axis_ready  out  1  input beat accepted
s_axis_data  in  DW  input beat
m_axis_valid  out  1  output beat valid
m_axis_ready  in  1  downstream ready
m_axis_data  out  DW  output beat
m_axis_last  out  1  last payload beat of a block (0 in passthrough)
reset_upack  out  1  reset to downstream unpacker
fifo_level  out  FIFO_DEPTH_LOG2+1  occupied entries
discarded_block_count  out  32  blocks dropped at input
late_block_count  out  32  blocks sent late (late_mode 1)
underflow_count  out  32  in-block starvation cycles

Behaviour:
- Reset: FIFO empty; beat counter 0; all counters 0; s_axis_ready=0; m_axis_valid=0; m_axis_last=0; reset_upack=1.
- Transfer start: a rising edge of s_axis_xfer_req gives a 2-cycle start pulse. During the pulse:
  - reset_upack=1; FIFO flushed; beat counter cleared; s_axis_ready=0.
  - reset_upack = reset OR start pulse at all times.
- FIFO: synchronous, first-word-fall-through. Entry = {ts_valid, last, ts, data}.
  - s_axis_ready = s_axis_xfer_req AND !start pulse AND (FIFO not full OR current beat is a header OR discard active).
  - A write and a read in the same cycle are allowed; no full bypass.
  - A beat accepted in cycle N is visible at the FIFO head in N+1.
- Beat counter, active when timestamp_every != 0: counts 0..timestamp_every on each accepted beat, then wraps to 0. Beat 0 is the header and is never written to the FIFO.
- Header classification, with limit = timestamp + timestamp_every*MULT computed at TIMESTAMP_WIDTH and saturated to all-ones:
  - ts > limit: too early; discard the block.
  - ts < timestamp and late_mode != 1: discard the block.
  - Otherwise accept. The first payload beat is written with ts_valid=1 and ts=header ts; all other beats have ts_valid=0.
  - Every discarded block increments discarded_block_count by 1. Payload beats of a discarded block are accepted and dropped without writing.
- Last marking: the payload beat at counter == timestamp_every is written with last=1.
- Output: m_axis_valid = FIFO not empty AND !start pulse AND (!head.ts_valid OR timestamp >= head.ts).
  - If the head has ts_valid=1 and head.ts < timestamp when it first becomes eligible, the block is released immediately and late_block_count increments once.
  - Pop on m_axis_valid AND m_axis_ready. m_axis_last = head.last AND m_axis_valid.
- Underflow: in_block is set on popping a ts_valid beat and cleared on popping a last beat. Each cycle with in_block=1, FIFO empty and m_axis_ready=1 increments underflow_count by 1.
- Passthrough (timestamp_every=0): no headers, no gating, last=0. Changing timestamp_every takes effect only from the next transfer start.
- s_axis_xfer_req falling: the beat counter resets to 0 and input stalls; FIFO contents still drain.
- Counters wrap at 2**32. An asynchronous reset in mid-block discards everything.

Test Plan:
1. every=4, DAC ts=100, header ts=120 + 4 beats -> m_axis_valid held low until timestamp=120, then 4 beats out, last on the 4th; counters stay 0.
2. every=4, late_mode=0, header ts=90 at timestamp=100 -> all 5 beats accepted, nothing output, discarded_block_count=1.
3. Same stimulus with late_mode=1 -> 4 beats released immediately, late_block_count=1, discarded_block_count=0.
4. every=4, MULT=16, header ts=100+65 at timestamp=100 -> block discarded; header ts=164 -> block accepted.
5. every=8, source pauses 3 cycles after the 2nd payload beat with m_axis_ready=1 -> underflow_count=3.
6. Depth 16, m_axis_ready=0, timestamp_every=0 -> 16 beats accepted, fifo_level=16, s_axis_ready=0. Then raise xfer_req from 0 -> reset_upack high 2 cycles, fifo_level=0.
